regfile_bank: RTL and testbench

Parametrised general-purpose register file for the MIPS datapath, replacing the fixed 32×32 register file. It provides two registered read ports and one byte-maskable write port, with an optional hardwired zero register. Write-to-read forwarding is selectable at compile time. It sits between decode (read addresses) and writeback (write port), and exposes one register combinationally for testbench observation.

---
 rtl/regfile_bank.sv | 99 +++++++++
 tb/tb_regfile_bank.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bank.sv
// regfile_bank: parametrised register file with two registered read ports,
// one byte-maskable write port and an optional hardwired zero register.
// Compile-time option: define REGFILE_BYPASS_EN to forward a same-cycle write
// into the read ports; leave it undefined so that reads see pre-write contents.
// register_v0 is a combinational view of register DEBUG_REG for observation.
module regfile_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int DEBUG_REG  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
  input  logic [ADDR_WIDTH-1:0]   read_address_1,
  input  logic [ADDR_WIDTH-1:0]   read_address_2,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data_1,
  output logic [DATA_WIDTH-1:0]   read_data_2,
  output logic [DATA_WIDTH-1:0]   register_v0
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] DEBUG_IDX = ADDR_WIDTH'(DEBUG_REG);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] rd_val_1;
  logic [DATA_WIDTH-1:0] rd_val_2;

  // Merge write data into the old register value byte by byte; decide whether
  // the write actually lands (zero register swallows writes).
  always_comb begin
    wr_old    = regs[write_address];
    wr_merged = wr_old;
    for (int k = 0; k < NBYTES; k++) begin
      if (wr_byte_en[k]) begin
        wr_merged[8*k +: 8] = write_data[8*k +: 8];
      end
    end
    wr_hit = en && wr_en && !((ZERO_REG != 0) && (write_address == '0));
  end

  // Select the value each read port will capture on the next edge.
  always_comb begin
    rd_val_1 = regs[read_address_1];
    rd_val_2 = regs[read_address_2];
`ifdef REGFILE_BYPASS_EN
    // wr_hit already excludes the zero register, so forwarding never
    // leaks a discarded write into address 0.
    if (wr_hit && (read_address_1 == write_address)) begin
      rd_val_1 = wr_merged;
    end
    if (wr_hit && (read_address_2 == write_address)) begin
      rd_val_2 = wr_merged;
    end
`endif
    if ((ZERO_REG != 0) && (read_address_1 == '0)) begin
      rd_val_1 = '0;
    end
    if ((ZERO_REG != 0) && (read_address_2 == '0)) begin
      rd_val_2 = '0;
    end
  end

  // Array update: reset clears everything, otherwise a masked write when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[write_address] <= wr_merged;
    end
  end

  // Read port registers: cleared by reset, captured on enabled reads, else held.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_1 <= '0;
      read_data_2 <= '0;
    end else if (en && rd_en) begin
      read_data_1 <= rd_val_1;
      read_data_2 <= rd_val_2;
    end
  end

  // Combinational observation port.
  assign register_v0 = regs[DEBUG_IDX];

endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed test of regfile_bank with hand-computed expectations.
// Expectations for same-cycle read/write follow REGFILE_BYPASS_EN, if defined.
module tb_regfile_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  wr_byte_en;
  logic [4:0]  read_address_1;
  logic [4:0]  read_address_2;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] register_v0;

  int total;
  int bad;

  regfile_bank #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .ZERO_REG(1),
    .DEBUG_REG(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .wr_byte_en(wr_byte_en),
    .read_address_1(read_address_1),
    .read_address_2(read_address_2),
    .write_address(write_address),
    .write_data(write_data),
    .read_data_1(read_data_1),
    .read_data_2(read_data_2),
    .register_v0(register_v0)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; write_address = a; write_data = d; wr_byte_en = m;
    tick();
    wr_en = 1'b0; wr_byte_en = 4'h0;
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
    rd_en = 1'b1; read_address_1 = a1; read_address_2 = a2;
    tick();
    rd_en = 1'b0;
  endtask

  logic [31:0] exp_same;
  logic [31:0] exp_part;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; en = 1'b1; rd_en = 1'b0; wr_en = 1'b0; wr_byte_en = 4'h0;
    read_address_1 = '0; read_address_2 = '0; write_address = '0; write_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_rd1", read_data_1, 32'h0);
    check("reset_rd2", read_data_2, 32'h0);
    check("reset_v0", register_v0, 32'h0);

    // preload, then reset with a write and read pending in the same cycle
    do_write(5'd5, 32'hCAFEF00D, 4'hF);
    do_write(5'd2, 32'h55AA55AA, 4'hF);
    check("preload_v0", register_v0, 32'h55AA55AA);
    do_read(5'd5, 5'd2);
    check("preload_rd1", read_data_1, 32'hCAFEF00D);
    check("preload_rd2", read_data_2, 32'h55AA55AA);
    rst = 1'b1; wr_en = 1'b1; write_address = 5'd5; write_data = 32'h12345678; wr_byte_en = 4'hF;
    rd_en = 1'b1; read_address_1 = 5'd5; read_address_2 = 5'd2;
    tick();
    rst = 1'b0; wr_en = 1'b0; wr_byte_en = 4'h0; rd_en = 1'b0;
    check("midrst_rd1", read_data_1, 32'h0);
    check("midrst_rd2", read_data_2, 32'h0);
    check("midrst_v0", register_v0, 32'h0);
    do_read(5'd5, 5'd2);
    check("midrst_a5", read_data_1, 32'h0);
    check("midrst_a2", read_data_2, 32'h0);

    // full write then read on both ports
    do_write(5'd2, 32'hDEADBEEF, 4'hF);
    check("full_v0", register_v0, 32'hDEADBEEF);
    do_read(5'd2, 5'd2);
    check("full_rd1", read_data_1, 32'hDEADBEEF);
    check("full_rd2", read_data_2, 32'hDEADBEEF);

    // byte mask
    do_write(5'd7, 32'h11223344, 4'hF);
    do_write(5'd7, 32'hAABBCCDD, 4'b0101);
    do_read(5'd7, 5'd7);
    check("mask_rd1", read_data_1, 32'h11BB33DD);
    check("mask_rd2", read_data_2, 32'h11BB33DD);

    // empty mask is a no-op
    do_write(5'd7, 32'h00000000, 4'h0);
    do_read(5'd7, 5'd2);
    check("nomask_rd1", read_data_1, 32'h11BB33DD);
    check("nomask_rd2", read_data_2, 32'hDEADBEEF);

    // zero register
    do_write(5'd0, 32'hFFFFFFFF, 4'hF);
    do_read(5'd0, 5'd0);
    check("zero_rd1", read_data_1, 32'h0);
    check("zero_rd2", read_data_2, 32'h0);

    // same-cycle read and write, full mask
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h12345678;
    exp_part = 32'h1234AAAA;
`else
    exp_same = 32'h00000000;
    exp_part = 32'h12345678;
`endif
    wr_en = 1'b1; write_address = 5'd3; write_data = 32'h12345678; wr_byte_en = 4'hF;
    rd_en = 1'b1; read_address_1 = 5'd3; read_address_2 = 5'd7;
    tick();
    wr_en = 1'b0; wr_byte_en = 4'h0; rd_en = 1'b0;
    check("same_rd1", read_data_1, exp_same);
    check("same_rd2_other", read_data_2, 32'h11BB33DD);
    do_read(5'd3, 5'd3);
    check("same_after", read_data_1, 32'h12345678);

    // same-cycle read and partial write
    wr_en = 1'b1; write_address = 5'd3; write_data = 32'hAAAAAAAA; wr_byte_en = 4'b0011;
    rd_en = 1'b1; read_address_1 = 5'd7; read_address_2 = 5'd3;
    tick();
    wr_en = 1'b0; wr_byte_en = 4'h0; rd_en = 1'b0;
    check("part_rd2", read_data_2, exp_part);
    do_read(5'd3, 5'd7);
    check("part_after", read_data_1, 32'h1234AAAA);

    // same-cycle write to zero register never forwards
    wr_en = 1'b1; write_address = 5'd0; write_data = 32'h5A5A5A5A; wr_byte_en = 4'hF;
    rd_en = 1'b1; read_address_1 = 5'd0; read_address_2 = 5'd0;
    tick();
    wr_en = 1'b0; wr_byte_en = 4'h0; rd_en = 1'b0;
    check("zero_same", read_data_1, 32'h0);

    // hold with rd_en low
    do_read(5'd2, 5'd2);
    read_address_1 = 5'd7; read_address_2 = 5'd3;
    tick();
    check("hold_rd1", read_data_1, 32'hDEADBEEF);
    check("hold_rd2", read_data_2, 32'hDEADBEEF);

    // en low freezes array and outputs
    en = 1'b0;
    wr_en = 1'b1; write_address = 5'd2; write_data = 32'h00000001; wr_byte_en = 4'hF;
    rd_en = 1'b1; read_address_1 = 5'd7; read_address_2 = 5'd3;
    tick();
    wr_en = 1'b0; wr_byte_en = 4'h0; rd_en = 1'b0;
    check("en0_v0", register_v0, 32'hDEADBEEF);
    check("en0_rd1", read_data_1, 32'hDEADBEEF);
    check("en0_rd2", read_data_2, 32'hDEADBEEF);
    en = 1'b1;
    do_read(5'd2, 5'd3);
    check("en0_nowrite", read_data_1, 32'hDEADBEEF);
    check("en1_rd2", read_data_2, 32'h1234AAAA);

    // reset wins over en low
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1;
    check("rst_en0_rd1", read_data_1, 32'h0);
    check("rst_en0_v0", register_v0, 32'h0);
    do_read(5'd7, 5'd3);
    check("rst_en0_a7", read_data_1, 32'h0);
    check("rst_en0_a3", read_data_2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
